// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
//
// Pointer and flag controller that turns an external dual-pointer storage
// array into a 2**ADDR_WIDTH-entry FIFO. The array itself lives outside this
// block; here we only decide when it may be written or read, which address to
// use, and how full the queue is.
//
// Ports
//   clk               : single clock, all state updates on the rising edge
//   reset             : asynchronous, active-high reset
//   push / pop        : write / read requests from the transaction layer
//   data_in           : write data, forwarded unchanged on mem_data_in
//   thr_almost_full   : almost_full asserts when count >= this value
//   thr_almost_empty  : almost_empty asserts when count <= this value
//   wr_en / rd_en     : memory write / read strobes (accepted requests only)
//   wr_ptr / rd_ptr   : memory write / read addresses
//   mem_data_in       : data_in pass-through to the memory
//   valid_out         : memory data_out holds the word read last cycle
//   count             : current occupancy, 0..DEPTH
//   full / empty      : occupancy at DEPTH / at zero
//   almost_full/empty : programmable threshold flags
//   fifo_error        : sticky overflow/underflow indicator, cleared by reset
// -----------------------------------------------------------------------------
module fifo_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   thr_almost_full,
  input  logic [ADDR_WIDTH:0]   thr_almost_empty,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error
);

  // Occupancy needs one bit more than the pointers so that "full" (DEPTH)
  // and "empty" (0) are distinguishable while the pointers are equal.
  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic                  valid_q,  valid_d;
  logic                  error_q,  error_d;

  // ---------------------------------------------------------------------------
  // Flag decode: purely from registered count, so flags never react to
  // push/pop within the same cycle. Thresholds are live inputs, so a change
  // to them is visible immediately.
  // ---------------------------------------------------------------------------
  logic is_full, is_empty;

  assign is_full      = (count_q == DEPTH_CNT);
  assign is_empty     = (count_q == '0);
  assign full         = is_full;
  assign empty        = is_empty;
  assign almost_full  = (count_q >= thr_almost_full);
  assign almost_empty = (count_q <= thr_almost_empty);

  // ---------------------------------------------------------------------------
  // Accept logic. Each side is judged only against its own boundary: a push
  // while full is refused even if a pop frees a slot this cycle, and a pop
  // while empty is refused even if a push arrives (no fall-through).
  // Strobes are masked during reset because the registered count already
  // reads zero, which alone would let a push through to the memory.
  // ---------------------------------------------------------------------------
  logic push_ok, pop_ok;

  assign push_ok = push & ~is_full  & ~reset;
  assign pop_ok  = pop  & ~is_empty & ~reset;

  assign wr_en       = push_ok;
  assign rd_en       = pop_ok;
  assign mem_data_in = data_in;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves
    // a combinational output unassigned would infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = pop_ok;
    error_d  = error_q;

    // Pointers wrap naturally at DEPTH because they are exactly ADDR_WIDTH bits.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;  // idle, or accepted push and pop together
    endcase

    // Errors are raised on the raw request, not the accepted one: the
    // refused request is exactly what we are reporting.
    if ((push & is_full) | (pop & is_empty)) error_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State register. Reset clears occupancy and pointers only; whatever the
  // memory array still holds is unreachable once count is zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values; blocking here would let later lines see updated state.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign wr_ptr     = wr_ptr_q;
  assign rd_ptr     = rd_ptr_q;
  assign count      = count_q;
  assign valid_out  = valid_q;
  assign fifo_error = error_q;

endmodule
